ex_ma_pipeline_reg: RTL

EX→MA pipeline register for the 32-bit pipelined processor, directly downstream of the ALU in the execute stage. Captures the ALU result, store operand, destination register and MA/WB control bits under a valid/ready handshake with stall and flush support. Owns the architectural 2-bit flags register: it is written only when a CMP instruction commits out of this stage.

---
 rtl/ex_ma_pipeline_reg.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/ex_ma_pipeline_reg.sv
// ex_ma_pipeline_reg
//   EX -> MA pipeline register sitting directly behind the ALU. It holds the
//   ALU result, the store operand, the PC, the destination register and the
//   opaque MA/WB control bundle under a valid/ready handshake. Stall and flush
//   are supported. The block also owns the architectural {gt, eq} flags. They
//   are written only when a CMP instruction leaves this stage towards MA.
//
// Build option:
//   EX_MA_SKID_EN  defined   : output entry plus one skid entry, ex_ready is
//                              registered (!FULL), with no path from ma_ready.
//                  undefined : single output entry,
//                              ex_ready = !ma_valid || ma_ready.
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   ex_valid / ex_ready            upstream handshake
//   ex_alu_result, ex_op2, ex_pc   datapath words from EX
//   ex_rd, ex_ctrl                 destination register, MA/WB control bundle
//   ex_is_cmp, ex_cmp_flags        CMP marker and its {gt, eq} result
//   flush                          drop held and incoming instructions
//   ma_valid / ma_ready            downstream handshake
//   ma_alu_result, ma_op2, ma_pc,
//   ma_rd, ma_ctrl                 registered copies towards MA
//   flags                          architectural {gt, eq}
module ex_ma_pipeline_reg #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 4,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_op2,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic [CTRL_W-1:0] ex_ctrl,
  input  logic              ex_is_cmp,
  input  logic [1:0]        ex_cmp_flags,
  input  logic              flush,
  output logic              ma_valid,
  input  logic              ma_ready,
  output logic [DATA_W-1:0] ma_alu_result,
  output logic [DATA_W-1:0] ma_op2,
  output logic [DATA_W-1:0] ma_pc,
  output logic [RD_W-1:0]   ma_rd,
  output logic [CTRL_W-1:0] ma_ctrl,
  output logic [1:0]        flags
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e state, state_nxt;

  logic accept, xfer;
  logic load_out;
  logic vld_p1;

  // Output entry (drives ma_*)
  logic [DATA_W-1:0] res_p1, op2_p1, pc_p1;
  logic [RD_W-1:0]   rd_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic              is_cmp_p1;
  logic [1:0]        cmp_flags_p1;

  // Next contents of the output entry: from EX, or from the skid entry
  logic [DATA_W-1:0] res_in, op2_in, pc_in;
  logic [RD_W-1:0]   rd_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic              is_cmp_in;
  logic [1:0]        cmp_flags_in;

  assign vld_p1 = (state != EMPTY);
  assign accept = ex_valid && ex_ready;
  assign xfer   = vld_p1 && ma_ready;

`ifdef EX_MA_SKID_EN
  logic load_skid, out_from_skid;

  // Skid entry: catches the beat accepted while the output entry is stalled
  logic [DATA_W-1:0] res_p0, op2_p0, pc_p0;
  logic [RD_W-1:0]   rd_p0;
  logic [CTRL_W-1:0] ctrl_p0;
  logic              is_cmp_p0;
  logic [1:0]        cmp_flags_p0;

  assign ex_ready = (state != FULL);

  always_comb begin
    state_nxt     = state;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    if (flush) begin
      // Any transfer this cycle still completes; everything else is dropped
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (accept) begin
          load_out  = 1'b1;
          state_nxt = ONE;
        end
        ONE: begin
          if (accept && xfer) begin
            load_out = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else if (xfer) begin
            state_nxt = EMPTY;
          end
        end
        FULL: if (xfer) begin
          load_out      = 1'b1;
          out_from_skid = 1'b1;
          state_nxt     = ONE;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    res_in       = out_from_skid ? res_p0       : ex_alu_result;
    op2_in       = out_from_skid ? op2_p0       : ex_op2;
    pc_in        = out_from_skid ? pc_p0        : ex_pc;
    rd_in        = out_from_skid ? rd_p0        : ex_rd;
    ctrl_in      = out_from_skid ? ctrl_p0      : ex_ctrl;
    is_cmp_in    = out_from_skid ? is_cmp_p0    : ex_is_cmp;
    cmp_flags_in = out_from_skid ? cmp_flags_p0 : ex_cmp_flags;
  end

  // ---- skid entry ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_p0       <= '0;
      op2_p0       <= '0;
      pc_p0        <= '0;
      rd_p0        <= '0;
      ctrl_p0      <= '0;
      is_cmp_p0    <= 1'b0;
      cmp_flags_p0 <= 2'b00;
    end else if (load_skid) begin
      res_p0       <= ex_alu_result;
      op2_p0       <= ex_op2;
      pc_p0        <= ex_pc;
      rd_p0        <= ex_rd;
      ctrl_p0      <= ex_ctrl;
      is_cmp_p0    <= ex_is_cmp;
      cmp_flags_p0 <= ex_cmp_flags;
    end
  end
`else
  // Single entry: a new beat can enter only if the held one leaves this cycle
  assign ex_ready = !vld_p1 || ma_ready;

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else if (accept) begin
      load_out  = 1'b1;
      state_nxt = ONE;
    end else if (xfer) begin
      state_nxt = EMPTY;
    end
  end

  always_comb begin
    res_in       = ex_alu_result;
    op2_in       = ex_op2;
    pc_in        = ex_pc;
    rd_in        = ex_rd;
    ctrl_in      = ex_ctrl;
    is_cmp_in    = ex_is_cmp;
    cmp_flags_in = ex_cmp_flags;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  // ---- output entry ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_p1       <= '0;
      op2_p1       <= '0;
      pc_p1        <= '0;
      rd_p1        <= '0;
      ctrl_p1      <= '0;
      is_cmp_p1    <= 1'b0;
      cmp_flags_p1 <= 2'b00;
    end else if (load_out) begin
      res_p1       <= res_in;
      op2_p1       <= op2_in;
      pc_p1        <= pc_in;
      rd_p1        <= rd_in;
      ctrl_p1      <= ctrl_in;
      is_cmp_p1    <= is_cmp_in;
      cmp_flags_p1 <= cmp_flags_in;
    end
  end

  // Flags commit on the transfer itself, so a flush in the same cycle cannot
  // stop a CMP that is already leaving.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                flags <= 2'b00;
    else if (xfer && is_cmp_p1)  flags <= cmp_flags_p1;
  end

  assign ma_valid      = vld_p1;
  assign ma_alu_result = res_p1;
  assign ma_op2        = op2_p1;
  assign ma_pc         = pc_p1;
  assign ma_rd         = rd_p1;
  assign ma_ctrl       = ctrl_p1;

endmodule
